// File: rtl/motor_encoder_pkg.sv
// motor_encoder_pkg: register map, field positions and step
// classification shared by the encoder slave and its decoders.
package motor_encoder_pkg;

  localparam logic [3:0] IDX_CTRL   = 4'h0;
  localparam logic [3:0] IDX_STATUS = 4'h1;
  localparam logic [3:0] IDX_POS0   = 4'h4;

  localparam int CTRL_CLR_LSB = 8;
  localparam int CTRL_IRQ_EN  = 16;
  localparam int STAT_DIR_LSB = 8;

  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_UP,
    STEP_DN,
    STEP_ERR
  } enc_step_e;

  // Position of an {a,b} pair along 00,01,11,10.
  function automatic logic [1:0] gray_idx(input logic [1:0] ab);
    return {ab[1], ab[1] ^ ab[0]};
  endfunction

  function automatic enc_step_e step_of(
    input logic [1:0] prev,
    input logic [1:0] cur
  );
    logic [1:0] d;
    d = gray_idx(cur) - gray_idx(prev);
    case (d)
      2'd1:    step_of = STEP_UP;
      2'd3:    step_of = STEP_DN;
      2'd2:    step_of = STEP_ERR;
      default: step_of = STEP_NONE;
    endcase
  endfunction

  function automatic logic [31:0] merge_strb(
    input logic [31:0] old,
    input logic [31:0] wd,
    input logic [3:0]  st
  );
    logic [31:0] r;
    for (int i = 0; i < 4; i++)
      r[i*8 +: 8] = st[i] ? wd[i*8 +: 8] : old[i*8 +: 8];
    return r;
  endfunction

endpackage

// File: rtl/quad_decoder_ch.sv
// quad_decoder_ch: one encoder channel -- synchroniser, glitch
// filter, 4x quadrature decode and wrapping position counter.
module quad_decoder_ch
  import motor_encoder_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                 ACLK,
  input  logic                 ARESETN,
  input  logic                 a,
  input  logic                 b,
  input  logic                 en,
  input  logic                 clr,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_val,
  output logic [CNT_WIDTH-1:0] pos,
  output logic                 dir,
  output logic                 err_pulse
);

  localparam int FW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic [SYNC_STAGES-1:0] a_sync, b_sync;
  logic [1:0]             s, filt, prev;
  logic [1:0][FW-1:0]     cnt;
  enc_step_e              step;

  assign s = {a_sync[SYNC_STAGES-1], b_sync[SYNC_STAGES-1]};

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      a_sync <= '0;
      b_sync <= '0;
    end else begin
      a_sync <= {a_sync[SYNC_STAGES-2:0], a};
      b_sync <= {b_sync[SYNC_STAGES-2:0], b};
    end
  end

  // Any sample equal to the filtered value restarts the run.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      filt <= '0;
      cnt  <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (s[i] == filt[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == FW'(FILT_LEN - 1)) begin
          filt[i] <= s[i];
          cnt[i]  <= '0;
        end else begin
          cnt[i] <= cnt[i] + FW'(1);
        end
      end
    end
  end

  assign step      = step_of(prev, filt);
  assign err_pulse = (step == STEP_ERR);

  // prev tracks even when disabled so re-enable adds no step.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      prev <= '0;
      pos  <= '0;
      dir  <= 1'b0;
    end else begin
      prev <= filt;
      if (clr) begin
        pos <= '0;
      end else if (load) begin
        pos <= load_val;
      end else if (en && step == STEP_UP) begin
        pos <= pos + CNT_WIDTH'(1);
        dir <= 1'b1;
      end else if (en && step == STEP_DN) begin
        pos <= pos - CNT_WIDTH'(1);
        dir <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/motor_encoder_axil_multi.sv
// motor_encoder_axil_multi: AXI4-Lite register bank in front of
// NUM_CH quadrature decoder channels.
module motor_encoder_axil_multi
  import motor_encoder_pkg::*;
#(
  parameter int NUM_CH             = 4,
  parameter int CNT_WIDTH          = 32,
  parameter int SYNC_STAGES        = 2,
  parameter int FILT_LEN           = 3,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 6
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  input  logic [NUM_CH-1:0]               enc_a,
  input  logic [NUM_CH-1:0]               enc_b,
  output logic                            enc_err_irq
);

  logic                 wr_en, rd_en, irq_en;
  logic [3:0]           widx, ridx;
  logic [NUM_CH-1:0]    ctrl_en, clr_q, load;
  logic [NUM_CH-1:0]    dir, err_pulse, err_q, w1c;
  logic [CNT_WIDTH-1:0] pos [NUM_CH];
  logic [31:0]          wmerge [NUM_CH];
  logic [31:0]          rd_mux;
  logic                 unused;

  assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                    S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign widx  = S_AXI_AWADDR[5:2];
  assign ridx  = S_AXI_ARADDR[5:2];
  assign wr_en = S_AXI_AWREADY && S_AXI_AWVALID && S_AXI_WVALID;
  assign rd_en = S_AXI_ARREADY && S_AXI_ARVALID;

  assign S_AXI_WREADY = S_AXI_AWREADY;
  assign S_AXI_BRESP  = 2'b00;
  assign S_AXI_RRESP  = 2'b00;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      S_AXI_AWREADY <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
    end else begin
      S_AXI_AWREADY <= S_AXI_AWVALID && S_AXI_WVALID &&
                       !S_AXI_AWREADY && !S_AXI_BVALID;
      if (wr_en)             S_AXI_BVALID <= 1'b1;
      else if (S_AXI_BREADY) S_AXI_BVALID <= 1'b0;
      S_AXI_ARREADY <= S_AXI_ARVALID &&
                       !S_AXI_ARREADY && !S_AXI_RVALID;
      if (rd_en) begin
        S_AXI_RVALID <= 1'b1;
        S_AXI_RDATA  <= rd_mux;
      end else if (S_AXI_RREADY) begin
        S_AXI_RVALID <= 1'b0;
      end
    end
  end

  assign w1c = (wr_en && widx == IDX_STATUS && S_AXI_WSTRB[0]) ?
               S_AXI_WDATA[NUM_CH-1:0] : '0;

  // A fresh error in the W1C cycle survives the clear.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ctrl_en <= '0;
      clr_q   <= '0;
      irq_en  <= 1'b0;
      err_q   <= '0;
    end else begin
      clr_q <= '0;
      err_q <= (err_q & ~w1c) | err_pulse;
      if (wr_en && widx == IDX_CTRL) begin
        if (S_AXI_WSTRB[0])
          ctrl_en <= S_AXI_WDATA[NUM_CH-1:0];
        if (S_AXI_WSTRB[1])
          clr_q <= S_AXI_WDATA[CTRL_CLR_LSB +: NUM_CH];
        if (S_AXI_WSTRB[2])
          irq_en <= S_AXI_WDATA[CTRL_IRQ_EN];
      end
    end
  end

  assign enc_err_irq = irq_en && (|err_q);

  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      ridx == IDX_CTRL:
        rd_mux = {15'b0, irq_en, 8'b0, 8'(ctrl_en)};
      ridx == IDX_STATUS:
        rd_mux = {16'b0, 8'(dir), 8'(err_q)};
      default: ;
    endcase
    for (int i = 0; i < NUM_CH; i++)
      if (ridx == IDX_POS0 + 4'(i))
        rd_mux = 32'(pos[i]);
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    assign wmerge[ch] = merge_strb(32'(pos[ch]),
                                   S_AXI_WDATA, S_AXI_WSTRB);
    assign load[ch] = wr_en && (widx == IDX_POS0 + 4'(ch));

    quad_decoder_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_LEN    (FILT_LEN),
      .CNT_WIDTH   (CNT_WIDTH)
    ) u_dec (
      .ACLK      (ACLK),
      .ARESETN   (ARESETN),
      .a         (enc_a[ch]),
      .b         (enc_b[ch]),
      .en        (ctrl_en[ch]),
      .clr       (clr_q[ch]),
      .load      (load[ch]),
      .load_val  (wmerge[ch][CNT_WIDTH-1:0]),
      .pos       (pos[ch]),
      .dir       (dir[ch]),
      .err_pulse (err_pulse[ch])
    );
  end

endmodule

// File: tb/tb_motor_encoder_axil_multi.sv
// tb_motor_encoder_axil_multi: vector table, hand-timed corner
// sequences and a phase-level random model of the encoder slave.
module tb_motor_encoder_axil_multi;

  localparam int NCH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  awaddr = '0, araddr = '0;
  logic [2:0]  awprot = '0, arprot = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b1;
  logic        arvalid = 1'b0, rready = 1'b1;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [31:0] wdata = '0, rdata;
  logic [3:0]  wstrb = '0;
  logic [1:0]  bresp, rresp;
  logic [NCH-1:0] enc_a = '0, enc_b = '0;
  logic        irq;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  motor_encoder_axil_multi dut (
    .ACLK(clk), .ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot),
    .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
    .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid),
    .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot),
    .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp),
    .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .enc_a(enc_a), .enc_b(enc_b), .enc_err_irq(irq)
  );

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic axi_write(input logic [5:0] addr,
                           input logic [31:0] data,
                           input logic [3:0] strb);
    int n;
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end
    while (!awready && n < 50);
    if (!awready) check("aw_timeout", 32'(awready), 1);
    check("wready", 32'(wready), 1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    check("bvalid", 32'(bvalid), 1);
    check("bresp", 32'(bresp), 0);
    @(posedge clk); #1;
  endtask

  task automatic axi_read(input logic [5:0] addr,
                          output logic [31:0] data);
    int n;
    araddr = addr; arvalid = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end
    while (!arready && n < 50);
    if (!arready) check("ar_timeout", 32'(arready), 1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    check("rvalid", 32'(rvalid), 1);
    data = rdata;
    check("rresp", 32'(rresp), 0);
    @(posedge clk); #1;
  endtask

  task automatic set_ab(input int ch, input logic [1:0] ab);
    enc_a[ch] = ab[1];
    enc_b[ch] = ab[0];
  endtask

  task automatic settle();
    repeat (10) @(posedge clk);
    #1;
  endtask

  typedef struct {
    int          ch;
    logic [1:0]  ab;
    logic [3:0]  en;
    logic [31:0] pos;
    logic [31:0] status;
  } vec_t;

  vec_t        tbl [8];
  logic [5:0]  rst_addr [6];
  logic [1:0]  gray_seq [4];
  int          mph [NCH];
  logic [31:0] mpos [NCH];
  logic [NCH-1:0] mdir, merr, men;
  logic [31:0] rd;

  initial begin
    #2ms;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{0, 2'b01, 4'h1, 32'd1, 32'h0100};
    tbl[1] = '{0, 2'b11, 4'h1, 32'd2, 32'h0100};
    tbl[2] = '{0, 2'b10, 4'h1, 32'd3, 32'h0100};
    tbl[3] = '{0, 2'b00, 4'h1, 32'd4, 32'h0100};
    tbl[4] = '{2, 2'b10, 4'h5, 32'hFFFF_FFFF, 32'h0100};
    tbl[5] = '{3, 2'b01, 4'h5, 32'd0, 32'h0100};
    tbl[6] = '{3, 2'b00, 4'hD, 32'hFFFF_FFFF, 32'h0100};
    tbl[7] = '{1, 2'b11, 4'hF, 32'd0, 32'h0102};
    rst_addr = '{6'h00, 6'h04, 6'h10, 6'h14, 6'h18, 6'h1C};
    gray_seq = '{2'b00, 2'b01, 2'b11, 2'b10};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_awready", 32'(awready), 0);
    check("rst_bvalid", 32'(bvalid), 0);
    check("rst_arready", 32'(arready), 0);
    check("rst_rvalid", 32'(rvalid), 0);
    check("rst_rdata", rdata, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      axi_read(rst_addr[i], rd);
      check($sformatf("rst_reg%0d", i), rd, 0);
    end
    check("rst_irq", 32'(irq), 0);

    // table: steps, wrap, frozen channel, illegal jump
    for (int i = 0; i < 8; i++) begin
      axi_write(6'h00, 32'h0001_0000 | 32'(tbl[i].en), 4'hF);
      @(posedge clk); #1;
      set_ab(tbl[i].ch, tbl[i].ab);
      settle();
      axi_read(6'h10 + 6'(4 * tbl[i].ch), rd);
      check($sformatf("tbl%0d_pos", i), rd, tbl[i].pos);
      axi_read(6'h04, rd);
      check($sformatf("tbl%0d_status", i), rd, tbl[i].status);
      check($sformatf("tbl%0d_irq", i), 32'(irq),
            32'(tbl[i].status[7:0] != 0));
    end
    axi_read(6'h14, rd);
    check("pos1_no_count_on_err", rd, 0);

    // W1C of the error bit
    axi_write(6'h04, 32'h2, 4'hF);
    axi_read(6'h04, rd);
    check("w1c_status", rd, 32'h0100);
    check("w1c_irq", 32'(irq), 0);

    // glitch shorter than the filter, then a real edge
    @(posedge clk); #1; set_ab(0, 2'b01);
    settle();
    axi_read(6'h10, rd);
    check("pre_glitch_pos", rd, 5);
    @(posedge clk); #1; enc_a[0] = 1'b1;
    repeat (2) @(posedge clk);
    #1; enc_a[0] = 1'b0;
    settle();
    axi_read(6'h10, rd);
    check("glitch_pos", rd, 5);
    @(posedge clk); #1; enc_a[0] = 1'b1;
    settle();
    axi_read(6'h10, rd);
    check("held_edge_pos", rd, 6);

    // POS write on the step edge, then a stalled B channel
    @(posedge clk); #1; set_ab(0, 2'b10);
    repeat (4) @(posedge clk);
    #1;
    awaddr = 6'h10; wdata = 32'h1234; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    @(posedge clk); #1;
    check("t6_awready", 32'(awready), 1);
    @(posedge clk); #1;
    check("t6_bvalid", 32'(bvalid), 1);
    awaddr = 6'h3C; wdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check($sformatf("t6_hold_bvalid%0d", i), 32'(bvalid), 1);
      check($sformatf("t6_no_awready%0d", i), 32'(awready), 0);
    end
    bready = 1'b1;
    begin
      int n;
      n = 0;
      while (!awready && n < 20) begin
        @(posedge clk); #1; n++;
      end
    end
    check("t6_second_aw", 32'(awready), 1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    @(posedge clk); #1;
    axi_read(6'h10, rd);
    check("t6_load_wins", rd, 32'h1234);

    // byte strobes on POS1
    axi_write(6'h14, 32'hAABB_CCDD, 4'h1);
    axi_read(6'h14, rd);
    check("strb_b0", rd, 32'h0000_00DD);
    axi_write(6'h14, 32'h1122_3344, 4'h4);
    axi_read(6'h14, rd);
    check("strb_b2", rd, 32'h0022_00DD);

    // clr pulse on ch0 only
    axi_write(6'h00, 32'h0001_010F, 4'hF);
    axi_read(6'h10, rd);
    check("clr_pos0", rd, 0);
    axi_read(6'h14, rd);
    check("clr_keeps_pos1", rd, 32'h0022_00DD);
    axi_read(6'h00, rd);
    check("ctrl_readback", rd, 32'h0001_000F);

    // unmapped space
    axi_write(6'h20, 32'hDEAD_BEEF, 4'hF);
    axi_read(6'h20, rd);
    check("unmapped_20", rd, 0);
    axi_read(6'h3C, rd);
    check("unmapped_3c", rd, 0);

    // edge-to-flag latency is 6 cycles
    @(posedge clk); #1; set_ab(3, 2'b11);
    repeat (5) @(posedge clk);
    #1;
    check("lat_irq_early", 32'(irq), 0);
    @(posedge clk); #1;
    check("lat_irq_on_time", 32'(irq), 1);

    // reset in the middle of traffic
    for (int c = 0; c < NCH; c++) set_ab(c, 2'b00);
    settle();
    check("pre_rst_irq", 32'(irq), 1);
    awaddr = 6'h10; wdata = 32'h55; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_awready", 32'(awready), 0);
    check("mid_rst_bvalid", 32'(bvalid), 0);
    check("mid_rst_irq", 32'(irq), 0);
    awvalid = 1'b0; wvalid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    axi_read(6'h10, rd);
    check("post_rst_pos0", rd, 0);
    axi_read(6'h00, rd);
    check("post_rst_ctrl", rd, 0);
    axi_read(6'h04, rd);
    check("post_rst_status", rd, 0);

    // random traffic against a phase-level model
    for (int c = 0; c < NCH; c++) begin
      mph[c] = 0;
      mpos[c] = '0;
    end
    mdir = '0; merr = '0; men = '0;
    for (int it = 0; it < 60; it++) begin
      int ch, act, delta;
      logic [31:0] d;
      logic [3:0]  s;
      ch  = $urandom_range(0, NCH - 1);
      act = $urandom_range(0, 6);
      if (act == 6) begin
        men = 4'($urandom);
        axi_write(6'h00, 32'(men), 4'hF);
      end else if (act == 5) begin
        d = $urandom;
        s = 4'($urandom);
        axi_write(6'h10 + 6'(4 * ch), d, s);
        for (int k = 0; k < 4; k++)
          if (s[k]) mpos[ch][k*8 +: 8] = d[k*8 +: 8];
      end else if (act == 4) begin
        s = 4'($urandom);
        axi_write(6'h04, 32'(s), 4'h1);
        merr = merr & ~s;
      end else begin
        delta = (act == 3) ? 2 : ((act == 2) ? 3 : 1);
        mph[ch] = (mph[ch] + delta) % 4;
        @(posedge clk); #1;
        set_ab(ch, gray_seq[mph[ch]]);
        settle();
        if (act == 3) begin
          merr[ch] = 1'b1;
        end else if (men[ch]) begin
          mpos[ch] = (act == 2) ? mpos[ch] - 1 : mpos[ch] + 1;
          mdir[ch] = (act != 2);
        end
      end
      axi_read(6'h10 + 6'(4 * ch), rd);
      check($sformatf("rnd%0d_pos%0d", it, ch), rd, mpos[ch]);
      axi_read(6'h04, rd);
      check($sformatf("rnd%0d_status", it), rd,
            {16'h0, 4'h0, mdir, 4'h0, merr});
    end
    for (int c = 0; c < NCH; c++) begin
      axi_read(6'h10 + 6'(4 * c), rd);
      check($sformatf("final_pos%0d", c), rd, mpos[c]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
